// File: rtl/pa_regfile_scoreboard_if.sv
// pa_regfile_scoreboard_if: read/write/reserve bus between decode and the register file
interface pa_regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RA, RB, RW, RsvAddr;
  logic [DATA_W-1:0] PA, PB, PW;
  logic              LE, RsvE, BusyA, BusyB;
  logic [ADDR_W:0]   BusyCnt;
  modport master (output RA, RB, RW, PW, LE, RsvE, RsvAddr, input PA, PB, BusyA, BusyB, BusyCnt);
  modport slave  (input RA, RB, RW, PW, LE, RsvE, RsvAddr, output PA, PB, BusyA, BusyB, BusyCnt);
endinterface

// File: rtl/pa_regfile_scoreboard.sv
// pa_regfile_scoreboard: 2R1W register file with RAW-hazard busy scoreboard and busy counter
module pa_regfile_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input logic Clk,
  input logic Clr,
  pa_regfile_scoreboard_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d, set, rel;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_ok, r0_a, r0_b;
  assign wr_ok = bus.LE && !(ZERO_R0 != 0 && bus.RW == '0);
  assign r0_a  = ZERO_R0 != 0 && bus.RA == '0;
  assign r0_b  = ZERO_R0 != 0 && bus.RB == '0;
  // next register contents: a single write port, R0 optionally read-only
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.RW] = bus.PW;
  end
  // next busy vector: a new reservation beats a same-edge release; popcount gives the next count
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      set[i]    = bus.RsvE && bus.RsvAddr == ADDR_W'(i);
      rel[i]    = bus.LE && bus.RW == ADDR_W'(i);
      busy_d[i] = (ZERO_R0 != 0 && i == 0) ? 1'b0 : (set[i] | (busy_q[i] & ~rel[i]));
      cnt_d     = cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end
  // state registers with synchronous clear that drops all pending reservations
  always_ff @(posedge Clk) begin
    if (Clr) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  // combinational read ports with optional same-cycle write forwarding
  always_comb begin
    bus.PA      = r0_a ? '0 : (BYPASS != 0 && wr_ok && bus.RA == bus.RW) ? bus.PW : regs_q[bus.RA];
    bus.PB      = r0_b ? '0 : (BYPASS != 0 && wr_ok && bus.RB == bus.RW) ? bus.PW : regs_q[bus.RB];
    bus.BusyA   = busy_q[bus.RA];
    bus.BusyB   = busy_q[bus.RB];
    bus.BusyCnt = cnt_q;
  end
endmodule
